multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 opcode  input  6  instruction[31:26] from the instruction register; only sampled in DECODE.
REQ-004 mem_ready  input  1  memory handshake; high when the current read or write completes this cycle.
REQ-005 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath strobes and selects.
REQ-006 ALUOp  output  2  00 add, 01 subtract (compare), 10 decode funct field.
REQ-007 ALUSrcB  output  2  00 reg B, 01 constant 4, 10 sign-extended imm, 11 imm shifted left 2.
REQ-008 PCSource  output  2  00 ALU result, 01 ALUOut register, 10 jump target.
REQ-009 illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-010 state  output  4  current state encoding, for debug.

Function
REQ-011 The state register SHALL hold one of: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ERROR=10; codes 11-15 SHALL go to FETCH on the next edge.
REQ-012 All outputs SHALL be 0 except as listed per state (REQ-013..023).
REQ-013 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready; go to DECODE when mem_ready=1, else stay in FETCH.
REQ-014 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state from opcode: 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 000010->JUMP (see REQ-028), any other->ERROR.
REQ-015 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEMRD if the opcode latched in DECODE is 100011, else MEMWR.
REQ-016 The block SHALL internally latch opcode in DECODE, and MEMADR SHALL use the latched value.
REQ-017 MEMRD: MemRead=1, IorD=1; go to MEMWB on mem_ready=1, else stay.
REQ-018 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
REQ-019 MEMWR: MemWrite=1, IorD=1; go to FETCH on mem_ready=1, else stay.
REQ-020 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next RWB. RWB: RegDst=1, MemtoReg=0, RegWrite=1; next FETCH.
REQ-021 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; next FETCH.
REQ-022 JUMP: PCWrite=1, PCSource=10; next FETCH.
REQ-023 ERROR: illegal=1 for exactly one cycle; next FETCH.
REQ-024 With mem_ready held at 1, the latency from entering FETCH back to FETCH SHALL be: R 4 cycles, LW 5, SW 4, BEQ 3, J 3, illegal 3; each low mem_ready cycle in FETCH, MEMRD or MEMWR SHALL add exactly one cycle.
REQ-025 mem_ready SHALL be ignored in all states other than FETCH, MEMRD and MEMWR.

Reset
REQ-026 When reset=1 at a rising edge, state SHALL become FETCH and the latched opcode 000000 regardless of current state, including mid-wait in MEMRD or MEMWR; reset SHALL take priority over mem_ready.
REQ-027 While in FETCH after reset, outputs SHALL follow REQ-013; no write strobe other than the FETCH strobes in REQ-013 SHALL be asserted in the cycle after reset.

Configuration
REQ-028 Macro JUMP_INSN_EN: when defined, opcode 000010 in DECODE SHALL go to JUMP; when undefined, the JUMP state SHALL not exist, 000010 SHALL go to ERROR, and PCSource SHALL never be 10.

Verification
REQ-029 Reset held 2 cycles mid-MEMRD -> state=0, MemRead=1, IorD=0, RegWrite=0 next cycle.
REQ-030 opcode=000000, mem_ready=1 -> states 0,1,6,7,0; RegWrite=1 with RegDst=1 only in state 7.
REQ-031 opcode=100011, mem_ready low 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; MemtoReg=1 and RegWrite=1 in state 4.
REQ-032 opcode=101011, mem_ready=0 for 3 cycles in FETCH -> IRWrite=0 for 3 cycles and 1 on the 4th, then states 1,2,5,0 with MemWrite=1 in state 5.
REQ-033 opcode=000100 -> states 0,1,8,0; PCWriteCond=1, ALUOp=01 in state 8.
REQ-034 opcode=000010 -> with JUMP_INSN_EN: states 0,1,9,0, PCSource=10; without it: states 0,1,10,0 with illegal=1 for one cycle; opcode=111111 -> illegal pulse in both builds.

Source files
------------

// File: rtl/multicycle_control_if.sv
//------------------------------------------------------------------------------
// Module      : multicycle_control_if
// Description : Datapath/controller bundle for the multicycle MIPS control FSM.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       ALUSrcA;
  logic       RegWrite;
  logic       RegDst;
  logic [1:0] ALUOp;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic       illegal;
  logic [3:0] state;

  // Controller side: consumes opcode/mem_ready, drives every strobe.
  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB, PCSource, illegal, state
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB, PCSource, illegal, state
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_control.sv
//------------------------------------------------------------------------------
// Module      : multicycle_control
// Description : Multicycle MIPS control FSM; JUMP_INSN_EN enables the J insn.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control (
  input wire logic           clk,
  input wire logic           reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
`ifdef JUMP_INSN_EN
    JUMP   = 4'd9,
`endif
    ERROR  = 4'd10
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
`ifdef JUMP_INSN_EN
  localparam logic [5:0] c_OP_J     = 6'b000010;
`endif

  state_t     r_state;
  state_t     w_nextState;
  logic [5:0] r_opcode;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= FETCH;
      r_opcode <= 6'b000000;
    end else begin
      r_state <= w_nextState;
      if (r_state == DECODE) begin
        r_opcode <= bus.opcode;
      end
    end
  end

  always_comb begin
    w_nextState     = FETCH;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.ALUOp       = 2'b00;
    bus.ALUSrcB     = 2'b00;
    bus.PCSource    = 2'b00;
    bus.illegal     = 1'b0;

    case (r_state)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
        w_nextState = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.ALUSrcB = 2'b11;
        case (bus.opcode)
          c_OP_RTYPE:     w_nextState = EXEC;
          c_OP_LW, c_OP_SW: w_nextState = MEMADR;
          c_OP_BEQ:       w_nextState = BRANCH;
`ifdef JUMP_INSN_EN
          c_OP_J:         w_nextState = JUMP;
`endif
          default:        w_nextState = ERROR;
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        // The live opcode may have moved on; only the DECODE copy is trusted.
        w_nextState = (r_opcode == c_OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        w_nextState = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
        w_nextState  = FETCH;
      end
      MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        w_nextState  = bus.mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
        w_nextState = RWB;
      end
      RWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
        w_nextState  = FETCH;
      end
      BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
        w_nextState     = FETCH;
      end
`ifdef JUMP_INSN_EN
      JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
        w_nextState  = FETCH;
      end
`endif
      ERROR: begin
        bus.illegal = 1'b1;
        w_nextState = FETCH;
      end
      default: w_nextState = FETCH;
    endcase
  end

  assign bus.state = r_state;

endmodule

`default_nettype wire
